// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request memory access sequencer.
// Setup / access / release handshake with timeout and load formatting.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        req_rw,
    input  logic [1:0]  req_mode,
    input  logic        req_signed,
    input  logic [6:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_enable,
    output logic        mem_w_r,
    output logic [1:0]  mem_mode,
    output logic [6:0]  mem_addr,
    output logic [31:0] mem_data,
    input  logic        mem_moc,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;

    logic        rw_q;
    logic [1:0]  mode_q;
    logic        sgn_q;
    logic [6:0]  addr_q;
    logic [31:0] wdata_q;

    logic        moc_m;
    logic        moc_s;
    logic [7:0]  tmo_cnt;

    logic        accept;
    logic        misaligned;
    logic        expire;
    logic [31:0] load_fmt;

    assign accept = (state == S_IDLE) && req;
    assign expire = (tmo_cnt == TMO_LAST);

    // Alignment of the incoming request; reserved mode always faults.
    always_comb begin
        misaligned = 1'b0;
        unique case (req_mode)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Right-aligned load data extended to 32 bits by the captured mode.
    always_comb begin
        load_fmt = mem_rdata;
        unique case (mode_q)
            2'b00: load_fmt = {{24{sgn_q & mem_rdata[7]}}, mem_rdata[7:0]};
            2'b01: load_fmt = {{16{sgn_q & mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_fmt = mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one cycle per phase except ACCESS.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = misaligned ? S_ERROR : S_SETUP;
                end
            end
            S_SETUP:   state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (moc_s) begin
                    state_nxt = S_RELEASE;
                end else if (expire) begin
                    state_nxt = S_ERROR;
                end
            end
            S_RELEASE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            S_ERROR:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Status and memory-bus outputs decoded from state and captured request.
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        err        = (state == S_ERROR);
        mem_enable = (state == S_ACCESS);
        mem_w_r    = rw_q;
        mem_mode   = mode_q;
        mem_addr   = addr_q;
        mem_data   = wdata_q;
    end

    // Request capture on acceptance; held stable for the whole access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rw_q    <= 1'b0;
            mode_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= 7'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            rw_q    <= req_rw;
            mode_q  <= req_mode;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Two-flop synchronizer for the asynchronous completion strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            moc_m <= 1'b0;
            moc_s <= 1'b0;
        end else begin
            moc_m <= mem_moc;
            moc_s <= moc_m;
        end
    end

    // Timeout counter: zero outside ACCESS, so it starts at 0 on entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= 8'd0;
        end else if (state == S_ACCESS) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= 8'd0;
        end
    end

    // Load result: updated only by a completed read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= 32'd0;
        end else if (state == S_ACCESS && moc_s && rw_q) begin
            rdata <= load_fmt;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random accesses against a
// timeline/arithmetic reference model of the access controller.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        req_rw;
    logic [1:0]  req_mode;
    logic        req_signed;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_enable;
    logic        mem_w_r;
    logic [1:0]  mem_mode;
    logic [6:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_moc;
    logic [31:0] mem_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_rdata;

    localparam int TMO = 15;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_rw     (req_rw),
        .req_mode   (req_mode),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_enable (mem_enable),
        .mem_w_r    (mem_w_r),
        .mem_mode   (mem_mode),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_moc    (mem_moc),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [1:0] mode,
                                        input logic sgn,
                                        input logic [31:0] mrd);
        logic [31:0] v;
        if (mode == 2'd0) begin
            v = mrd % 32'd256;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (mode == 2'd1) begin
            v = mrd % 32'd65536;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = mrd;
        end
        return v;
    endfunction

    function automatic bit faulty(input logic [1:0] mode,
                                  input logic [6:0] addr);
        int size;
        size = 1 << mode;
        return (mode == 2'd3) || ((int'(addr) % size) != 0);
    endfunction

    // One request; moc_at = negedge index (after accept) where the
    // memory raises moc, 0 = memory never answers.
    task automatic run_access(input string tag, input logic rw,
                              input logic [1:0] mode, input logic sgn,
                              input logic [6:0] addr,
                              input logic [31:0] wdata,
                              input logic [31:0] mrd,
                              input int moc_at, input int moc_len);
        int en_cnt = 0;
        int en_first = -1;
        int done_cnt = 0;
        int done_at = -1;
        int err_cnt = 0;
        int err_at = -1;
        int bus_bad = 0;
        int both = 0;
        bit bad;
        bad = faulty(mode, addr);
        @(negedge clk);
        req        = 1'b1;
        req_rw     = rw;
        req_mode   = mode;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_rdata  = mrd;
        mem_moc    = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 1) req = 1'b0;
            if (mem_enable) begin
                en_cnt++;
                if (en_first < 0) en_first = n;
                if (mem_addr !== addr || mem_mode !== mode ||
                    mem_w_r !== rw || mem_data !== wdata) bus_bad++;
            end
            if (done) begin done_cnt++; done_at = n; end
            if (err) begin err_cnt++; err_at = n; end
            if (done && err) both++;
            mem_moc = (moc_at > 0 && n >= moc_at && n < moc_at + moc_len);
        end
        mem_moc = 1'b0;
        if (bad) begin
            check({tag, " en_cnt"}, en_cnt, 0);
            check({tag, " err_cnt"}, err_cnt, 1);
            check({tag, " err_at"}, err_at, 1);
            check({tag, " done_cnt"}, done_cnt, 0);
        end else if (moc_at == 0) begin
            check({tag, " en_first"}, en_first, 2);
            check({tag, " en_cnt"}, en_cnt, TMO);
            check({tag, " err_cnt"}, err_cnt, 1);
            check({tag, " err_at"}, err_at, TMO + 2);
            check({tag, " done_cnt"}, done_cnt, 0);
            check({tag, " bus"}, bus_bad, 0);
        end else begin
            check({tag, " en_first"}, en_first, 2);
            check({tag, " en_cnt"}, en_cnt, moc_at + 1);
            check({tag, " done_cnt"}, done_cnt, 1);
            check({tag, " done_at"}, done_at, moc_at + 4);
            check({tag, " err_cnt"}, err_cnt, 0);
            check({tag, " bus"}, bus_bad, 0);
            if (rw) model_rdata = fmt(mode, sgn, mrd);
        end
        check({tag, " both"}, both, 0);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " rdata"}, rdata, model_rdata);
    endtask

    initial begin
        int busy_rise;
        int en_rise;
        int dcnt;
        bit prev_busy;
        bit prev_en;
        logic [31:0] mrds [3];
        model_rdata = 32'd0;
        reset_n    = 1'b0;
        req        = 1'b0;
        req_rw     = 1'b0;
        req_mode   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 7'd0;
        req_wdata  = 32'd0;
        mem_moc    = 1'b0;
        mem_rdata  = 32'd0;

        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst rdata", rdata, 0);
        check("rst en", mem_enable, 0);
        check("rst mem_data", mem_data, 0);
        check("rst mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_access("wr04", 1, 2'd2, 0, 7'h04, 32'h0, 32'h800000FF, 3, 2);
        run_access("bs05", 1, 2'd0, 1, 7'h05, 32'h0, 32'h000000F0, 2, 1);
        run_access("bu05", 1, 2'd0, 0, 7'h05, 32'h0, 32'h000000F0, 4, 3);
        run_access("hs", 1, 2'd1, 1, 7'h06, 32'h0, 32'h00008001, 5, 2);

        // Reset in the middle of an access.
        @(negedge clk);
        req = 1'b1; req_rw = 1'b1; req_mode = 2'd2;
        req_addr = 7'h08; req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        check("pre-rst en", mem_enable, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid-rst en", mem_enable, 0);
        check("mid-rst busy", busy, 0);
        check("mid-rst rdata", rdata, 0);
        check("mid-rst mem_data", mem_data, 0);
        model_rdata = 32'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post-rst done", done, 0);
        check("post-rst err", err, 0);
        run_access("wr00", 1, 2'd2, 0, 7'h00, 32'h0, 32'h12345678, 3, 2);

        run_access("hw03", 0, 2'd1, 0, 7'h03, 32'h1111, 32'h0, 3, 1);
        run_access("wr02", 1, 2'd2, 0, 7'h02, 32'h0, 32'hFFFF0000, 3, 1);
        run_access("m11", 1, 2'd3, 0, 7'h00, 32'h0, 32'hFFFF0000, 3, 1);
        run_access("tmo", 0, 2'd2, 0, 7'h10, 32'hDEADBEEF, 32'h0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic       rw;
            logic [1:0] mode;
            logic [6:0] addr;
            int         mat;
            rw   = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            addr = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) addr = addr & ~7'((1 << mode) - 1);
            mat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 12);
            run_access("rnd", rw, mode, 1'($urandom_range(0, 1)), addr,
                       $urandom, $urandom, mat, $urandom_range(1, 3));
        end

        // Three back-to-back byte reads with req held high.
        mrds[0] = 32'h00000081;
        mrds[1] = 32'h0000007F;
        mrds[2] = 32'hFFFFFF10;
        busy_rise = 0; en_rise = 0; dcnt = 0;
        @(negedge clk);
        prev_busy = busy; prev_en = mem_enable;
        req = 1'b1; req_rw = 1'b1; req_mode = 2'd0;
        req_signed = 1'b1; req_addr = 7'h05;
        mem_rdata = mrds[0];
        for (int n = 0; n < 100 && dcnt < 3; n++) begin
            @(negedge clk);
            if (busy && !prev_busy) busy_rise++;
            if (mem_enable && !prev_en) en_rise++;
            prev_busy = busy;
            prev_en = mem_enable;
            mem_moc = mem_enable;
            if (done) begin
                check("b2b rdata", rdata, fmt(2'd0, 1'b1, mrds[dcnt]));
                dcnt++;
                if (dcnt == 3) req = 1'b0;
                else mem_rdata = mrds[dcnt];
            end
        end
        mem_moc = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b done_cnt", dcnt, 3);
        check("b2b busy_rise", busy_rise, 3);
        check("b2b en_rise", en_rise, 3);
        check("b2b busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
